// File: rtl/pio_prog_loader.sv
// Purpose : writer side of the PIO instruction store; streams host words into a 32-entry memory at an origin, optional JMP relocation, publishes wrap bounds, serves the PC fetch port.
// Latency : one write per accepted handshake; done pulses the cycle after the last handshake; rd_data is combinational (zero latency).
// Backpr. : in_ready is high only in LOAD; the host may stall in_valid arbitrarily; start is honoured only in IDLE.
//
// Ports: clk/reset_n (async active-low); start/abort/origin/length/relocate load control;
//        in_valid/in_data/in_ready host stream; busy/done/err status; wrap_bottom/wrap_top
//        bounds of the last completed program; rd_addr/rd_data fetch port.
module pio_prog_loader #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  origin,
    input  logic [ADDR_W:0]    length,
    input  logic               relocate,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_data,
    output logic               in_ready,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [ADDR_W-1:0]  wrap_bottom,
    output logic [ADDR_W-1:0]  wrap_top,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [INSTR_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;
    // Memory depth expressed in the width of the length port (32 in 6 bits).
    localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                load_go;
    logic                err_nxt;
    logic                hs;
    logic                len_ok;
    logic [ADDR_W-1:0]   org;
    logic [ADDR_W-1:0]   top;
    logic                rel;
    logic [ADDR_W-1:0]   wptr;
    logic [ADDR_W:0]     remaining;
    logic [INSTR_W-1:0]  word;
    logic [ADDR_W-1:0]   jmp_tgt;
    logic [INSTR_W-1:0]  mem [DEPTH];

    assign in_ready = (state == LOAD);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign hs       = in_valid & in_ready;
    assign len_ok   = (length != '0) && (length <= DEPTH_L);

    // JMP has opcode 3'b000 in the top bits; its target sits in the low ADDR_W bits.
    assign jmp_tgt = in_data[ADDR_W-1:0] + org;
    always_comb begin
        word = in_data;
        if (rel && (in_data[INSTR_W-1 -: 3] == 3'b000)) begin
            word = {in_data[INSTR_W-1:ADDR_W], jmp_tgt};
        end
    end

    always_comb begin
        state_nxt = state;
        load_go   = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        load_go   = 1'b1;
                        state_nxt = LOAD;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            LOAD: begin
                // Abort outranks completion: a final word taken with abort still
                // gets written, but the load never reports done.
                if (abort) begin
                    state_nxt = IDLE;
                end else if (hs && (remaining == {{ADDR_W{1'b0}}, 1'b1})) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            err         <= 1'b0;
            org         <= '0;
            top         <= '0;
            rel         <= 1'b0;
            wptr        <= '0;
            remaining   <= '0;
            wrap_bottom <= '0;
            wrap_top    <= {ADDR_W{1'b1}};
        end else begin
            state <= state_nxt;
            err   <= err_nxt;
            if (load_go) begin
                org       <= origin;
                // length==32 truncates to 0 here, giving origin-1 mod 32 as intended.
                top       <= origin + length[ADDR_W-1:0] - 1'b1;
                rel       <= relocate;
                wptr      <= origin;
                remaining <= length;
            end
            if (hs) begin
                wptr      <= wptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (state == DONE) begin
                wrap_bottom <= org;
                wrap_top    <= top;
            end
        end
    end

    // Memory is deliberately not reset; contents survive reset and aborted loads.
    always_ff @(posedge clk) begin
        if (hs) begin
            mem[wptr] <= word;
        end
    end

    // Write lands on the edge, so a same-cycle read of the written address sees old data.
    assign rd_data = mem[rd_addr];

endmodule

// File: tb/tb_pio_prog_loader.sv
module tb_pio_prog_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  origin = '0;
    logic [5:0]  length = '0;
    logic        relocate = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [4:0]  wrap_bottom;
    logic [4:0]  wrap_top;
    logic [4:0]  rd_addr = '0;
    logic [15:0] rd_data;

    pio_prog_loader #(.ADDR_W(5), .INSTR_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .origin(origin), .length(length), .relocate(relocate),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .busy(busy), .done(done), .err(err),
        .wrap_bottom(wrap_bottom), .wrap_top(wrap_top),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_mis = 0;
    logic [20:0] exp_q [$];      // {addr, word} expected in memory
    logic [15:0] mdl   [32];
    bit          mdl_ok [32];
    logic [15:0] wbuf  [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] reloc(input logic [15:0] d, input logic r, input logic [4:0] o);
        logic [4:0] t;
        t = d[4:0] + o;
        if (r && d[15:13] == 3'b000) return {d[15:5], t};
        return d;
    endfunction

    // Drain the scoreboard through the fetch port.
    task automatic verify();
        logic [20:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rd_addr = e[20:16];
            #1;
            chk($sformatf("mem[%0d]", e[20:16]), rd_data, e[15:0]);
        end
    endtask

    // Load n words from wbuf. stall: idle cycle before each word; poke: start with
    // length 0 during stalls; abort2: abort with the 2nd handshake; rdw: read-during-write check.
    task automatic do_load(input logic [4:0] o, input int n, input logic r,
                           input bit stall, input bit poke, input bit abort2, input bit rdw);
        logic [4:0]  a;
        logic [15:0] w;
        bit          aborted;
        aborted = 0;
        @(negedge clk);
        start = 1; origin = o; length = 6'(n); relocate = r;
        @(negedge clk);
        start = 0; origin = 5'd13; length = 6'd0; relocate = ~r;
        for (int i = 0; i < n && !aborted; i++) begin
            if (stall) begin
                in_valid = 0;
                if (poke) start = 1;
                @(negedge clk);
                start = 0;
                chk("err_ignored_in_load", err, 0);
            end
            chk("in_ready_load", in_ready, 1);
            chk("busy_load", busy, 1);
            chk("no_early_done", done, 0);
            a = o + 5'(i);
            w = reloc(wbuf[i], r, o);
            in_valid = 1; in_data = wbuf[i];
            if (rdw && i == 0) begin
                rd_addr = a;
                #1;
                chk("rdw_old", rd_data, mdl[a]);
            end
            exp_q.push_back({a, w});
            mdl[a] = w; mdl_ok[a] = 1;
            if (abort2 && i == 1) begin
                abort = 1;
                aborted = 1;
            end
            @(negedge clk);
            abort = 0;
            if (rdw && i == 0) chk("rdw_new", rd_data, w);
        end
        in_valid = 0;
        if (!aborted) begin
            chk("done_pulse", done, 1);
            chk("busy_done", busy, 1);
            chk("ready_done", in_ready, 0);
            @(negedge clk);
            chk("done_clear", done, 0);
            chk("busy_idle", busy, 0);
            chk("wrap_bottom", wrap_bottom, o);
            chk("wrap_top", wrap_top, 5'(o + 5'(n) - 5'd1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin mdl[i] = 'x; mdl_ok[i] = 0; end
        #12;
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wrap_bottom", wrap_bottom, 0);
        chk("rst_wrap_top", wrap_top, 31);
        reset_n = 1;

        // Plain load at origin 4.
        wbuf[0] = 16'hE001; wbuf[1] = 16'h0005; wbuf[2] = 16'hA042;
        do_load(5'd4, 3, 0, 0, 0, 0, 0);
        verify();
        rd_addr = 5'd5; #1;
        chk("fetch_5", rd_data, 16'h0005);

        // Wrapping load with relocation.
        wbuf[0] = 16'h0001; wbuf[1] = 16'h001F; wbuf[2] = 16'h2000; wbuf[3] = 16'h0003;
        do_load(5'd30, 4, 1, 0, 0, 0, 0);
        chk("reloc_30", exp_q[0][15:0], 16'h001F);
        chk("reloc_31", exp_q[1][15:0], 16'h001D);
        chk("reloc_1", exp_q[3][15:0], 16'h0001);
        verify();

        // Illegal lengths.
        foreach (wbuf[k]) wbuf[k] = '0;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            start = 1; origin = 5'd9; length = (t == 0) ? 6'd0 : 6'd33;
            @(negedge clk);
            start = 0;
            chk("err_pulse", err, 1);
            chk("err_ready", in_ready, 0);
            chk("err_busy", busy, 0);
            @(negedge clk);
            chk("err_clear", err, 0);
            chk("err_wrap_bottom", wrap_bottom, 30);
            chk("err_wrap_top", wrap_top, 1);
        end

        // Stalled host, with a start poked mid-load.
        for (int i = 0; i < 5; i++) wbuf[i] = 16'hC100 + 16'(i);
        do_load(5'd8, 5, 0, 1, 1, 0, 0);
        verify();

        // Abort together with the 2nd handshake, over a known preload.
        for (int i = 0; i < 5; i++) wbuf[i] = 16'h4001 + 16'(i);
        do_load(5'd0, 5, 0, 0, 0, 0, 0);
        verify();
        for (int i = 0; i < 4; i++) wbuf[i] = 16'h6100 + 16'(i) * 16'h0100;
        do_load(5'd0, 4, 0, 0, 0, 1, 1);
        chk("abort_ready", in_ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_no_done", done, 0);
        chk("abort_wrap_bottom", wrap_bottom, 0);
        chk("abort_wrap_top", wrap_top, 4);
        verify();
        rd_addr = 5'd2; #1; chk("abort_untouched2", rd_data, 16'h4003);
        rd_addr = 5'd3; #1; chk("abort_untouched3", rd_data, 16'h4004);
        mdl[2] = 16'h4003; mdl[3] = 16'h4004;
        wbuf[0] = 16'h0007;
        do_load(5'd20, 1, 0, 0, 0, 0, 0);
        verify();

        // Full-memory load from origin 7.
        for (int i = 0; i < 32; i++) wbuf[i] = 16'h8000 + 16'(i) * 16'd3;
        do_load(5'd7, 32, 0, 0, 0, 0, 0);
        verify();

        // Asynchronous reset in the middle of a load.
        wbuf[0] = 16'h1234; wbuf[1] = 16'h5678;
        @(negedge clk);
        start = 1; origin = 5'd16; length = 6'd4; relocate = 0;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_data = wbuf[i];
            exp_q.push_back({5'(16 + i), wbuf[i]});
            mdl[16 + i] = wbuf[i];
            @(negedge clk);
        end
        chk("pre_rst_busy", busy, 1);
        #2;
        reset_n = 0;
        #1;
        chk("arst_ready", in_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_wrap_bottom", wrap_bottom, 0);
        chk("arst_wrap_top", wrap_top, 31);
        in_valid = 0;
        verify();
        @(negedge clk);
        reset_n = 1;

        // Sweep every address the model knows.
        for (int i = 0; i < 32; i++) begin
            if (mdl_ok[i]) begin
                rd_addr = 5'(i); #1;
                chk($sformatf("sweep[%0d]", i), rd_data, mdl[i]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
